// File: rtl/dnn_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
package dnn_pkg;

    // Every operand and result occupies one 4-byte word in SDRAM.
    localparam int WORD_BYTES = 4;

    // Widest operand the fixed-point helper handles. Narrower words are sign-extended into it.
    localparam int FX_MAX_W = 64;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_RD_BIAS,
        S_WT_BIAS,
        S_RD_W,
        S_WT_W,
        S_RD_A,
        S_WT_A,
        S_MAC,
        S_WR,
        S_NEXT,
        S_FIN
    } state_t;

    // Full-precision signed product rescaled by frac_bits.
    // The arithmetic shift truncates toward -inf.
    function automatic logic signed [2*FX_MAX_W-1:0] fx_mul(
        input logic signed [FX_MAX_W-1:0] w,
        input logic signed [FX_MAX_W-1:0] a,
        input int                         frac_bits
    );
        logic signed [2*FX_MAX_W-1:0] prod;
        prod = (2*FX_MAX_W)'(w) * (2*FX_MAX_W)'(a);
        return prod >>> frac_bits;
    endfunction

endpackage

// File: rtl/dnn_fx_mac.sv
// Combinational fixed-point multiply-accumulate: acc_next = acc + ((w * a) >>> FRAC_BITS).
// The sum wraps in DATA_W bits and is never saturated. DATA_W must not exceed 64.
module dnn_fx_mac
    import dnn_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic signed [DATA_W-1:0] acc,
    input  logic signed [DATA_W-1:0] w,
    input  logic signed [DATA_W-1:0] a,
    output logic signed [DATA_W-1:0] acc_next
);

    // Rescale the product, keep its low DATA_W bits and add them to the accumulator.
    always_comb begin
        acc_next = acc + DATA_W'(fx_mul(FX_MAX_W'(w), FX_MAX_W'(a), FRAC_BITS));
    end

endmodule

// File: rtl/dnn_layer_engine.sv
// Avalon-MM master computing one fully-connected layer:
//   out[n] = relu?(bias[n] + sum_k W[n][k] * activ[k]).
// Operands are read one word at a time. Each result is written back once its row is finished.
//
// Bus handshake: a request (master_read or master_write) is presented together with its
// address (and write data). It is held unchanged until a cycle in which
// master_waitrequest is low; that cycle completes the request. Each read then waits in a
// WT_* state for exactly one master_readdatavalid, so at most one read is outstanding.
module dnn_layer_engine
    import dnn_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [31:0]       bias_v_addr,
    input  logic [31:0]       weight_m_addr,
    input  logic [31:0]       activ_addr,
    input  logic [31:0]       out_activ_addr,
    input  logic [LEN_W-1:0]  activ_len,
    input  logic [LEN_W-1:0]  out_len,
    input  logic              relu,
    input  logic              master_waitrequest,
    output logic [31:0]       master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata
);

    localparam int ADDR_SHIFT = $clog2(WORD_BYTES);

    state_t state;
    state_t state_next;

    // Job parameters captured when start is accepted.
    logic [31:0]       bias_base;
    logic [31:0]       w_base;
    logic [31:0]       a_base;
    logic [31:0]       o_base;
    logic [LEN_W-1:0]  a_len;
    logic [LEN_W-1:0]  o_len;
    logic              relu_q;

    // n: output index. k: input index.
    // w_off: running word offset into W, which equals n*activ_len + k because rows are contiguous.
    logic [LEN_W-1:0]  n;
    logic [LEN_W-1:0]  k;
    logic [31:0]       w_off;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] acc_next;

    dnn_fx_mac #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .acc      (acc),
        .w        (w_q),
        .a        (a_q),
        .acc_next (acc_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic: each read leaves RD_* on the first cycle waitrequest is low,
    // then waits in WT_* for its data.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_LATCH;
            S_LATCH:   state_next = (o_len == '0) ? S_FIN : S_RD_BIAS;
            S_RD_BIAS: if (!master_waitrequest) state_next = S_WT_BIAS;
            S_WT_BIAS: if (master_readdatavalid) state_next = (a_len == '0) ? S_WR : S_RD_W;
            S_RD_W:    if (!master_waitrequest) state_next = S_WT_W;
            S_WT_W:    if (master_readdatavalid) state_next = S_RD_A;
            S_RD_A:    if (!master_waitrequest) state_next = S_WT_A;
            S_WT_A:    if (master_readdatavalid) state_next = S_MAC;
            S_MAC:     state_next = (k == a_len - LEN_W'(1)) ? S_WR : S_RD_W;
            S_WR:      if (!master_waitrequest) state_next = S_NEXT;
            S_NEXT:    state_next = (n == o_len - LEN_W'(1)) ? S_FIN : S_RD_BIAS;
            S_FIN:     state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Bus and status outputs, decoded from the state and the current indices.
    always_comb begin
        busy             = (state != S_IDLE) && (state != S_FIN);
        done             = (state == S_FIN);
        master_read      = 1'b0;
        master_write     = 1'b0;
        master_address   = '0;
        master_writedata = '0;
        case (state)
            S_RD_BIAS: begin
                master_read    = 1'b1;
                master_address = bias_base + (32'(n) << ADDR_SHIFT);
            end
            S_RD_W: begin
                master_read    = 1'b1;
                master_address = w_base + (w_off << ADDR_SHIFT);
            end
            S_RD_A: begin
                master_read    = 1'b1;
                master_address = a_base + (32'(k) << ADDR_SHIFT);
            end
            S_WR: begin
                master_write     = 1'b1;
                master_address   = o_base + (32'(n) << ADDR_SHIFT);
                master_writedata = (relu_q && acc[DATA_W-1]) ? '0 : acc;
            end
            default: ;
        endcase
    end

    // Datapath: snapshot the job on start, capture read data, accumulate and step the indices.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_base <= '0;
            w_base    <= '0;
            a_base    <= '0;
            o_base    <= '0;
            a_len     <= '0;
            o_len     <= '0;
            relu_q    <= 1'b0;
            n         <= '0;
            k         <= '0;
            w_off     <= '0;
            acc       <= '0;
            w_q       <= '0;
            a_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bias_base <= bias_v_addr;
                        w_base    <= weight_m_addr;
                        a_base    <= activ_addr;
                        o_base    <= out_activ_addr;
                        a_len     <= activ_len;
                        o_len     <= out_len;
                        relu_q    <= relu;
                    end
                end
                S_LATCH: begin
                    n     <= '0;
                    k     <= '0;
                    w_off <= '0;
                end
                S_WT_BIAS: if (master_readdatavalid) acc <= master_readdata;
                S_WT_W:    if (master_readdatavalid) w_q <= master_readdata;
                S_WT_A:    if (master_readdatavalid) a_q <= master_readdata;
                S_MAC: begin
                    acc   <= acc_next;
                    k     <= k + LEN_W'(1);
                    w_off <= w_off + 32'd1;
                end
                S_NEXT: begin
                    n <= n + LEN_W'(1);
                    k <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_layer_engine.sv
// Bench for dnn_layer_engine: an SDRAM slave model with optional random waitrequest and
// read latency, directed layer vectors with hand-computed results, and a bus monitor that
// pops and compares expected reads and writes.
`timescale 1ns/1ps
module tb_dnn_layer_engine;

    localparam int DATA_W    = 32;
    localparam int FRAC_BITS = 16;
    localparam int LEN_W     = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [31:0]       bias_v_addr    = '0;
    logic [31:0]       weight_m_addr  = '0;
    logic [31:0]       activ_addr     = '0;
    logic [31:0]       out_activ_addr = '0;
    logic [LEN_W-1:0]  activ_len      = '0;
    logic [LEN_W-1:0]  out_len        = '0;
    logic              relu           = 1'b0;
    logic              master_waitrequest;
    logic [31:0]       master_address;
    logic              master_read;
    logic [DATA_W-1:0] master_readdata;
    logic              master_readdatavalid;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;

    dnn_layer_engine #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .LEN_W     (LEN_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .busy                 (busy),
        .done                 (done),
        .bias_v_addr          (bias_v_addr),
        .weight_m_addr        (weight_m_addr),
        .activ_addr           (activ_addr),
        .out_activ_addr       (out_activ_addr),
        .activ_len            (activ_len),
        .out_len              (out_len),
        .relu                 (relu),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    // ---------------- scoreboard state ----------------
    logic [31:0] mem [0:255];
    logic [63:0] exp_q[$];       // expected writes as {address, data}
    logic [31:0] exp_rd_q[$];    // expected read addresses, in order
    int compared   = 0;
    int mismatched = 0;

    // slave model controls
    bit          stall_en = 1'b0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          rd_accepted = 1'b0;
    bit          rd_pending  = 1'b0;
    int          rd_delay    = 0;
    logic [7:0]  rd_index    = '0;
    logic [7:0]  acc_index   = '0;
    int          rd_count    = 0;

    localparam logic [31:0] BIAS_A = 32'h0000_0100;
    localparam logic [31:0] W_A    = 32'h0000_0200;
    localparam logic [31:0] ACT_A  = 32'h0000_0300;
    localparam logic [31:0] OUT_A  = 32'h0000_0380;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: got %h, want none", name, act);
    endtask

    // ---------------- SDRAM slave model ----------------
    initial begin
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(posedge clk);
            #1;
            master_readdatavalid = 1'b0;
            if (rd_accepted) begin
                rd_accepted = 1'b0;
                rd_pending  = 1'b1;
                rd_delay    = int'($urandom_range(lat_max, lat_min));
                rd_index    = acc_index;
            end
            if (rd_pending) begin
                if (rd_delay <= 1) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = mem[rd_index];
                    rd_pending           = 1'b0;
                end else begin
                    rd_delay--;
                end
            end
            master_waitrequest = stall_en ? 1'($urandom_range(1, 0)) : 1'b0;
        end
    end

    // ---------------- bus monitor ----------------
    initial begin
        bit          prev_rd_stall;
        bit          prev_wr_stall;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        prev_rd_stall = 1'b0;
        prev_wr_stall = 1'b0;
        prev_addr     = '0;
        prev_wdata    = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_rd_stall = 1'b0;
                prev_wr_stall = 1'b0;
            end else begin
                if (prev_rd_stall) begin
                    check("rd_hold", master_read, 1);
                    check("rd_addr_hold", master_address, prev_addr);
                end
                if (prev_wr_stall) begin
                    check("wr_hold", master_write, 1);
                    check("wr_addr_hold", master_address, prev_addr);
                    check("wr_data_hold", master_writedata, prev_wdata);
                end
                if (master_read === 1'b1 && master_waitrequest === 1'b0) begin
                    check("one_outstanding", rd_pending | rd_accepted, 0);
                    if (exp_rd_q.size() == 0) fail_now("rd_unexpected", master_address);
                    else check("rd_addr", master_address, exp_rd_q.pop_front());
                    rd_accepted = 1'b1;
                    acc_index   = master_address[9:2];
                    rd_count++;
                end
                if (master_write === 1'b1 && master_waitrequest === 1'b0) begin
                    if (exp_q.size() == 0) fail_now("wr_unexpected", {master_address, master_writedata});
                    else check("wr_addr_data", {master_address, master_writedata}, exp_q.pop_front());
                    mem[master_address[9:2]] = master_writedata;
                end
                prev_rd_stall = (master_read === 1'b1) && (master_waitrequest === 1'b1);
                prev_wr_stall = (master_write === 1'b1) && (master_waitrequest === 1'b1);
                prev_addr     = master_address;
                prev_wdata    = master_writedata;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic push_reads(input logic [31:0] b, input logic [31:0] w, input logic [31:0] a,
                              input int alen, input int olen);
        for (int n = 0; n < olen; n++) begin
            exp_rd_q.push_back(b + 32'(4 * n));
            for (int k = 0; k < alen; k++) begin
                exp_rd_q.push_back(w + 32'(4 * (n * alen + k)));
                exp_rd_q.push_back(a + 32'(4 * k));
            end
        end
    endtask

    task automatic drive_job(input int alen, input int olen, input bit rl);
        bias_v_addr    = BIAS_A;
        weight_m_addr  = W_A;
        activ_addr     = ACT_A;
        out_activ_addr = OUT_A;
        activ_len      = LEN_W'(alen);
        out_len        = LEN_W'(olen);
        relu           = rl;
    endtask

    task automatic run_layer(input string tag, input int alen, input int olen, input bit rl,
                             input bit disturb, input int exp_cyc);
        int cyc;
        bit seen;
        push_reads(BIAS_A, W_A, ACT_A, alen, olen);
        @(posedge clk);
        #1;
        drive_job(alen, olen, rl);
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 3000) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_busy_after_start"}, busy, 1);
            if (done === 1'b1) seen = 1'b1;
            else if (disturb && cyc == 12) begin
                start      = 1'b1;
                activ_addr = 32'h0000_0040;
                out_len    = LEN_W'(7);
                relu       = ~rl;
            end
        end
        if (!seen) begin
            fail_now({tag, "_done_timeout"}, 64'(cyc));
        end else begin
            check({tag, "_busy_at_done"}, busy, 0);
            if (exp_cyc > 0) check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
            @(posedge clk);
            #1;
            check({tag, "_done_one_cycle"}, done, 0);
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_writes_left"}, 64'(exp_q.size()), 0);
        check({tag, "_reads_left"}, 64'(exp_rd_q.size()), 0);
        exp_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic load_basic();
        mem[64]  = 32'h0001_0000;
        mem[128] = 32'h0002_0000;
        mem[129] = 32'h0003_0000;
        mem[192] = 32'h0000_8000;
        mem[193] = 32'h0001_0000;
    endtask

    task automatic load_relu();
        mem[64]  = 32'hFFFC_0000;
        mem[65]  = 32'h0001_0000;
        mem[128] = 32'h0001_0000;
        mem[129] = 32'h0001_0000;
        mem[192] = 32'h0001_0000;
    endtask

    task automatic load_3x2();
        mem[64]  = 32'h0000_0000;
        mem[65]  = 32'h0000_8000;
        mem[128] = 32'h0001_0000;
        mem[129] = 32'h0002_0000;
        mem[130] = 32'hFFFF_0000;
        mem[131] = 32'h0000_8000;
        mem[132] = 32'h0000_0000;
        mem[133] = 32'h0004_0000;
        mem[192] = 32'h0003_0000;
        mem[193] = 32'h0001_0000;
        mem[194] = 32'h0002_0000;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base;
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", master_read, 0);
        check("rst_write", master_write, 0);
        check("rst_address", master_address, 0);
        check("rst_writedata", master_writedata, 0);
        rst_n = 1'b1;

        // Basic layer: 1.0 + 2*0.5 + 3*1 = 5.0
        load_basic();
        push_wr(OUT_A, 32'h0005_0000);
        run_layer("basic", 2, 1, 1'b0, 1'b0, 0);

        // ReLU on/off: -4+1 = -3, 1+1 = 2
        load_relu();
        push_wr(OUT_A, 32'h0000_0000);
        push_wr(OUT_A + 32'd4, 32'h0002_0000);
        run_layer("relu_on", 1, 2, 1'b1, 1'b0, 0);
        push_wr(OUT_A, 32'hFFFD_0000);
        push_wr(OUT_A + 32'd4, 32'h0002_0000);
        run_layer("relu_off", 1, 2, 1'b0, 1'b0, 0);

        // Truncation toward -inf and wrap: 0x7FFF8000 - 1 + 0x10000 = 0x80007FFF
        mem[64]  = 32'h7FFF_8000;
        mem[128] = 32'hFFFF_FFFF;
        mem[129] = 32'h0001_0000;
        mem[192] = 32'h0000_0001;
        mem[193] = 32'h0001_0000;
        push_wr(OUT_A, 32'h8000_7FFF);
        run_layer("trunc_wrap", 2, 1, 1'b0, 1'b0, 0);

        // out_len = 0: no traffic, done two cycles after start
        run_layer("out_len0", 2, 0, 1'b0, 1'b0, 2);

        // activ_len = 0: biases copied unchanged
        mem[64] = 32'h1234_5678;
        mem[65] = 32'hFFFF_0000;
        mem[66] = 32'h0000_0001;
        push_wr(OUT_A, 32'h1234_5678);
        push_wr(OUT_A + 32'd4, 32'hFFFF_0000);
        push_wr(OUT_A + 32'd8, 32'h0000_0001);
        run_layer("activ_len0", 0, 3, 1'b0, 1'b0, 0);

        // Waitrequest stress with random read latency
        stall_en = 1'b1;
        lat_min  = 1;
        lat_max  = 5;
        load_basic();
        push_wr(OUT_A, 32'h0005_0000);
        run_layer("stress_basic", 2, 1, 1'b0, 1'b0, 0);
        load_relu();
        push_wr(OUT_A, 32'h0000_0000);
        push_wr(OUT_A + 32'd4, 32'h0002_0000);
        run_layer("stress_relu", 1, 2, 1'b1, 1'b0, 0);

        // Start while busy plus input changes mid-layer: out0 = 3.0, out1 = 10.0
        load_3x2();
        push_wr(OUT_A, 32'h0003_0000);
        push_wr(OUT_A + 32'd4, 32'h000A_0000);
        run_layer("start_busy", 3, 2, 1'b0, 1'b1, 0);

        // Reset while waiting for the first weight
        stall_en = 1'b0;
        lat_min  = 5;
        lat_max  = 5;
        load_basic();
        push_reads(BIAS_A, W_A, ACT_A, 2, 1);
        base = rd_count;
        @(posedge clk);
        #1;
        drive_job(2, 1, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (rd_count < base + 2 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (rd_count < base + 2) fail_now("rst_mid_wait_timeout", 64'(rd_count - base));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_read", master_read, 0);
        check("rst_mid_write", master_write, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        rst_n = 1'b1;
        exp_rd_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_stale_ignored", busy, 0);
        lat_min = 1;
        lat_max = 3;
        push_wr(OUT_A, 32'h0005_0000);
        run_layer("after_reset", 2, 1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dnn_layer_engine.md
Name: dnn_layer_engine

Overview:
- Avalon-MM master that computes one fully-connected DNN layer: out[n] = relu?(bias[n] + sum_k W[n][k]*activ[k]) for n = 0..out_len-1.
- Operands are signed fixed-point words read from SDRAM; results are written back to SDRAM.
- Successor to the single-dot-product master: generalised to arbitrary layer shape (activ_len x out_len), parametrised data width and fraction bits, optional ReLU, and a start/busy/done handshake.
- Sits between the CPU-side control registers and the SDRAM interconnect.

Parameters:
- DATA_W, 32: word width of all operands and of the Avalon data bus.
- FRAC_BITS, 16: number of fractional bits in the fixed-point format (Q(DATA_W-FRAC_BITS).FRAC_BITS).
- LEN_W, 16: width of activ_len and out_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that launches a layer
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last output word is accepted
- bias_v_addr  in  32  byte address of the bias vector (out_len words)
- weight_m_addr  in  32  byte address of W, row-major, out_len x activ_len words
- activ_addr  in  32  byte address of the input activations (activ_len words)
- out_activ_addr  in  32  byte address of the output vector (out_len words)
- activ_len  in  LEN_W  number of inputs
- out_len  in  LEN_W  number of outputs
- relu  in  1  apply ReLU to each output
- master_waitrequest  in  1  Avalon waitrequest
- master_address  out  32  byte address
- master_read  out  1  read request
- master_readdata  in  DATA_W  read data
- master_readdatavalid  in  1  read data valid
- master_write  out  1  write request
- master_writedata  out  DATA_W  write data

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. In reset: state IDLE; busy=0, done=0, master_read=0, master_write=0, master_address=0, master_writedata=0; accumulator and counters cleared.
- Reset mid-operation: outstanding requests are dropped the next cycle, with no further reads or writes. A late readdatavalid arriving in IDLE is ignored.
- Start acceptance:
  - start is honoured only in IDLE; it is ignored while busy.
  - On acceptance, all addresses, lengths and relu are snapshotted. Later input changes have no effect on the running layer.
- States: IDLE -> LATCH -> (out_len==0 ? FIN : RD_BIAS). RD_BIAS -> WT_BIAS -> (activ_len==0 ? WR : RD_W). RD_W -> WT_W -> RD_A -> WT_A -> MAC -> (k==activ_len-1 ? WR : RD_W). WR -> NEXT -> (n==out_len-1 ? FIN : RD_BIAS). FIN -> IDLE.
- Read handshake:
  - In RD_*, master_read=1 and master_address are held stable while master_waitrequest=1.
  - The state leaves RD_* on the first cycle with waitrequest=0.
  - WT_* waits for readdatavalid and captures readdata.
  - Only one read is outstanding at any time.
- Write handshake: in WR, master_write=1, address and writedata are held until waitrequest=0.
- Addresses (byte, 4-byte stride):
  - bias: bias_v_addr + 4n
  - weight: weight_m_addr + 4(n*activ_len + k), 32-bit wrap
  - activation: activ_addr + 4k
  - output: out_activ_addr + 4n
- Arithmetic:
  - WT_BIAS: acc = bias.
  - MAC: full 2*DATA_W signed product of w and a, arithmetic shift right by FRAC_BITS (truncation toward -inf), then add to acc. Addition is DATA_W two's-complement and wraps; there is no saturation.
  - WR: writedata = (relu && acc[DATA_W-1]) ? 0 : acc.
- Boundaries:
  - activ_len=0: each output is relu?(bias); weights and activations are not read.
  - out_len=0: no bus traffic; done pulses 2 cycles after start.
- done: asserted one cycle in FIN; busy drops in the same cycle.

Decomposition:
- Package dnn_pkg: state enum type, WORD_BYTES=4 constant, fixed-point helper function (fx_mul) parametrised by FRAC_BITS.
- Sub-module dnn_fx_mac: combinational signed multiply, shift and add (inputs acc, w, a; output acc_next). It is reused by later multi-lane versions.
- The top level holds the FSM, counters, snapshots and the bus interface.

Test Plan:
- Basic layer:
  - Stimulus: activ_len=2, out_len=1, bias=0x00010000, W=[0x00020000, 0x00030000], activ=[0x00008000, 0x00010000].
  - Required response: one write of 0x00050000 to out_activ_addr, then a done pulse; reads occur in order bias, w0, a0, w1, a1.
- ReLU:
  - Stimulus: activ_len=1, out_len=2, bias=[0xFFFC0000, 0x00010000], W=[0x00010000, 0x00010000], activ=[0x00010000], relu=1.
  - Required response: writes 0x00000000 and 0x00020000.
  - Same stimulus with relu=0: first write is 0xFFFD0000.
- Waitrequest stress: random waitrequest at 50% and readdatavalid latency of 1-5 cycles. Required response: identical results; address and read/write held stable while waitrequest is high; never more than one outstanding read.
- Degenerate lengths:
  - out_len=0: zero bus transactions, and done arrives 2 cycles after start.
  - activ_len=0, out_len=3: bias words are copied to the output unchanged.
- Start while busy / input change: a second start mid-layer is ignored, and changing activ_addr mid-layer does not alter the addresses used; exactly out_len writes occur.
- Reset mid-layer: assert rst_n=0 during WT_W. Required response: read and write go low the next cycle, busy=0, and a stale readdatavalid is ignored. A following start runs correctly.
